// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type codes, head/payload layouts and injector state.
package noc_pkg;

  localparam int unsigned FLIT_W  = 16;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned WORD_W  = 14;
  localparam int unsigned MAX_LEN = 255;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic [1:0]         ftype;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [LEN_W-1:0]   len;
  } head_t;

  typedef struct packed {
    logic [1:0]        ftype;
    logic [WORD_W-1:0] data;
  } payload_t;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } inj_state_e;

endpackage

// File: rtl/ni_credit_counter.sv
// Credit counter mirroring a downstream buffer: starts full, -1 per send, +1 per returned credit.
// count_nxt_c lets the owner register signals that depend on next-cycle credit availability.
module ni_credit_counter #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             has_credit,
  output logic             err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] count_q;
  logic             has_credit_q;
  logic             err_q;
  logic             err_d;

  // Simultaneous send and return cancel; a return while full is a protocol error.
  always_comb begin
    count_nxt_c = count_q;
    err_d       = err_q;
    case ({dec, inc})
      2'b10: if (count_q != '0) count_nxt_c = count_q - CNT_W'(1);
      2'b01: begin
        if (count_q == FULL) err_d = 1'b1;
        else                 count_nxt_c = count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= FULL;
      has_credit_q <= (BUF_DEPTH != 0);
      err_q        <= 1'b0;
    end else begin
      count_q      <= count_nxt_c;
      has_credit_q <= (count_nxt_c != '0);
      err_q        <= err_d;
    end
  end

  assign count      = count_q;
  assign has_credit = has_credit_q;
  assign err        = err_q;

endmodule

// File: rtl/local_flit_injector.sv
// Node-side injector for a router local port: turns a descriptor plus payload words into
// head/body/tail flits and sends them under credit flow control.
module local_flit_injector
  import noc_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pkt_valid_i,
  output logic               pkt_ready_o,
  input  logic [COORD_W-1:0] pkt_dst_x_i,
  input  logic [COORD_W-1:0] pkt_dst_y_i,
  input  logic [LEN_W-1:0]   pkt_len_i,
  input  logic               wd_valid_i,
  output logic               wd_ready_o,
  input  logic [WORD_W-1:0]  wd_data_i,
  output logic [FLIT_W-1:0]  flit_o,
  output logic               valid_o,
  input  logic               credit_i,
  output logic [2:0]         credits_o,
  output logic               cred_err_o
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  inj_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  flit_t            flit_q, flit_d;
  logic             valid_q;
  logic             pkt_ready_q, pkt_ready_d;
  logic             wd_ready_q, wd_ready_d;
  head_t            head;
  payload_t         pay;

  logic             pkt_hs_c, wd_hs_c, send_c;
  logic [CNT_W-1:0] credit_cnt, credit_cnt_nxt;
  logic             has_credit, credit_err;

  ni_credit_counter #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_credit (
    .clk         (clk),
    .rst_n       (reset),
    .dec         (send_c),
    .inc         (credit_i),
    .count       (credit_cnt),
    .count_nxt_c (credit_cnt_nxt),
    .has_credit  (has_credit),
    .err         (credit_err)
  );

  assign pkt_hs_c = (state_q == IDLE) && pkt_valid_i && pkt_ready_q && has_credit;
  assign wd_hs_c  = (state_q == BODY) && wd_valid_i && wd_ready_q && has_credit;
  assign send_c   = pkt_hs_c || wd_hs_c;

  // Next state, flit build and next-cycle ready flags (ready follows next-cycle credits).
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    flit_d  = flit_q;
    head    = '0;
    pay     = '0;
    case (state_q)
      IDLE: begin
        if (pkt_hs_c) begin
          head.ftype = (pkt_len_i == '0) ? FT_SINGLE : FT_HEAD;
          head.dst_x = pkt_dst_x_i;
          head.dst_y = pkt_dst_y_i;
          head.len   = pkt_len_i;
          flit_d     = flit_t'(head);
          rem_d      = pkt_len_i;
          state_d    = (pkt_len_i == '0) ? IDLE : BODY;
        end
      end
      BODY: begin
        if (wd_hs_c) begin
          pay.ftype = (rem_q == LEN_W'(1)) ? FT_TAIL : FT_BODY;
          pay.data  = wd_data_i;
          flit_d    = flit_t'(pay);
          rem_d     = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pkt_ready_d = (state_d == IDLE) && (credit_cnt_nxt != '0);
    wd_ready_d  = (state_d == BODY) && (credit_cnt_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      flit_q      <= '0;
      valid_q     <= 1'b0;
      pkt_ready_q <= 1'b0;
      wd_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      flit_q      <= flit_d;
      valid_q     <= send_c;
      pkt_ready_q <= pkt_ready_d;
      wd_ready_q  <= wd_ready_d;
    end
  end

  assign flit_o      = flit_q;
  assign valid_o     = valid_q;
  assign pkt_ready_o = pkt_ready_q;
  assign wd_ready_o  = wd_ready_q;
  assign credits_o   = 3'(credit_cnt);
  assign cred_err_o  = credit_err;

endmodule

// File: tb/tb_local_flit_injector.sv
// Directed bench for local_flit_injector: flit encoding, credit flow control, reset and throughput.
module tb_local_flit_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [2:0]  pkt_dst_x_i;
  logic [2:0]  pkt_dst_y_i;
  logic [7:0]  pkt_len_i;
  logic        wd_valid_i;
  logic        wd_ready_o;
  logic [13:0] wd_data_i;
  logic [15:0] flit_o;
  logic        valid_o;
  logic        credit_i;
  logic [2:0]  credits_o;
  logic        cred_err_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] got[$];
  int          gcyc[$];

  local_flit_injector #(.BUF_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_valid_i (pkt_valid_i),
    .pkt_ready_o (pkt_ready_o),
    .pkt_dst_x_i (pkt_dst_x_i),
    .pkt_dst_y_i (pkt_dst_y_i),
    .pkt_len_i   (pkt_len_i),
    .wd_valid_i  (wd_valid_i),
    .wd_ready_o  (wd_ready_o),
    .wd_data_i   (wd_data_i),
    .flit_o      (flit_o),
    .valid_o     (valid_o),
    .credit_i    (credit_i),
    .credits_o   (credits_o),
    .cred_err_o  (cred_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Flit monitor: records every flit on the wire with its cycle number.
  always @(negedge clk) begin
    if (valid_o) begin
      got.push_back(flit_o);
      gcyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    got.delete();
    gcyc.delete();
    idle(1);
  endtask

  task automatic put_desc(input logic [2:0] x, input logic [2:0] y, input logic [7:0] len);
    int n = 0;
    pkt_dst_x_i = x;
    pkt_dst_y_i = y;
    pkt_len_i   = len;
    pkt_valid_i = 1'b1;
    while (!pkt_ready_o && n < 50) begin
      idle(1);
      n++;
    end
    check("desc_ready", 32'(pkt_ready_o), 32'd1);
    idle(1);
    pkt_valid_i = 1'b0;
  endtask

  task automatic put_word(input logic [13:0] d);
    int n = 0;
    wd_data_i  = d;
    wd_valid_i = 1'b1;
    while (!wd_ready_o && n < 50) begin
      idle(1);
      n++;
    end
    check("word_ready", 32'(wd_ready_o), 32'd1);
    idle(1);
    wd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pkt_valid_i = 1'b0; pkt_dst_x_i = '0; pkt_dst_y_i = '0; pkt_len_i = '0;
    wd_valid_i = 1'b0; wd_data_i = '0; credit_i = 1'b0;

    // Reset values
    idle(2);
    check("rst_valid",     32'(valid_o),     32'd0);
    check("rst_flit",      32'(flit_o),      32'h0);
    check("rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
    check("rst_wd_ready",  32'(wd_ready_o),  32'd0);
    check("rst_credits",   32'(credits_o),   32'd4);
    check("rst_err",       32'(cred_err_o),  32'd0);
    reset = 1'b1;
    idle(1);
    check("idle_ready", 32'(pkt_ready_o), 32'd1);

    // 1: single-flit packet
    put_desc(3'd2, 3'd5, 8'd0);
    check("t1_valid", 32'(valid_o), 32'd1);
    idle(2);
    check("t1_count",   32'(got.size()), 32'd1);
    check("t1_flit",    32'(got[0]),     32'hD500);
    check("t1_credits", 32'(credits_o),  32'd3);
    check("t1_hold",    32'(flit_o),     32'hD500);
    check("t1_pulse",   32'(valid_o),    32'd0);

    // 2: len=3, no credit return
    do_reset();
    put_desc(3'd1, 3'd1, 8'd3);
    put_word(14'h0AA);
    put_word(14'h0BB);
    put_word(14'h0CC);
    idle(2);
    check("t2_count",   32'(got.size()), 32'd4);
    check("t2_head",    32'(got[0]),     32'h8903);
    check("t2_body0",   32'(got[1]),     32'h00AA);
    check("t2_body1",   32'(got[2]),     32'h00BB);
    check("t2_tail",    32'(got[3]),     32'h40CC);
    check("t2_credits", 32'(credits_o),  32'd0);
    check("t2_noready", 32'(pkt_ready_o), 32'd0);

    // 3: len=6 stalls after 4 flits; one credit releases exactly one more
    do_reset();
    put_desc(3'd4, 3'd3, 8'd6);
    put_word(14'h001);
    put_word(14'h002);
    put_word(14'h003);
    wd_data_i  = 14'h0123;
    wd_valid_i = 1'b1;
    idle(3);
    check("t3_stall_cnt",   32'(got.size()),  32'd4);
    check("t3_stall_ready", 32'(wd_ready_o),  32'd0);
    check("t3_stall_cred",  32'(credits_o),   32'd0);
    credit_i = 1'b1;
    idle(1);
    credit_i = 1'b0;
    check("t3_ready_back", 32'(wd_ready_o), 32'd1);
    idle(1);
    wd_valid_i = 1'b0;
    idle(3);
    check("t3_one_more", 32'(got.size()), 32'd5);
    check("t3_body",     32'(got[4]),     32'h0123);
    check("t3_reblock",  32'(wd_ready_o), 32'd0);

    // 4: send+credit same cycle, then saturation error
    do_reset();
    put_desc(3'd0, 3'd0, 8'd0);
    put_desc(3'd0, 3'd0, 8'd0);
    check("t4_two", 32'(credits_o), 32'd2);
    pkt_dst_x_i = 3'd0; pkt_dst_y_i = 3'd0; pkt_len_i = 8'd0;
    pkt_valid_i = 1'b1;
    credit_i    = 1'b1;
    idle(1);
    pkt_valid_i = 1'b0;
    credit_i    = 1'b0;
    check("t4_cancel", 32'(credits_o), 32'd2);
    credit_i = 1'b1;
    idle(2);
    check("t4_full", 32'(credits_o),  32'd4);
    check("t4_noerr", 32'(cred_err_o), 32'd0);
    idle(1);
    credit_i = 1'b0;
    check("t4_sat", 32'(credits_o),  32'd4);
    check("t4_err", 32'(cred_err_o), 32'd1);
    idle(3);
    check("t4_sticky", 32'(cred_err_o), 32'd1);

    // 5: reset during a body
    do_reset();
    put_desc(3'd1, 3'd2, 8'd5);
    put_word(14'h111);
    check("t5_mid_valid", 32'(valid_o), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_valid",   32'(valid_o),     32'd0);
    check("t5_rst_credits", 32'(credits_o),   32'd4);
    check("t5_rst_err",     32'(cred_err_o),  32'd0);
    idle(1);
    reset = 1'b1;
    got.delete();
    gcyc.delete();
    idle(1);
    check("t5_idle",       32'(pkt_ready_o), 32'd1);
    check("t5_no_wdready", 32'(wd_ready_o),  32'd0);
    put_desc(3'd3, 3'd4, 8'd0);
    idle(2);
    check("t5_count", 32'(got.size()), 32'd1);
    check("t5_head",  32'(got[0]),     32'hDC00);

    // 6: two len=1 packets back to back with a credit every cycle
    do_reset();
    pkt_valid_i = 1'b1;
    wd_valid_i  = 1'b1;
    credit_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pkt_dst_x_i = (i < 2) ? 3'd0 : 3'd7;
      pkt_dst_y_i = (i < 2) ? 3'd7 : 3'd0;
      pkt_len_i   = 8'd1;
      wd_data_i   = (i < 2) ? 14'h011 : 14'h022;
      idle(1);
    end
    pkt_valid_i = 1'b0;
    wd_valid_i  = 1'b0;
    credit_i    = 1'b0;
    idle(2);
    check("t6_count", 32'(got.size()), 32'd4);
    check("t6_head0", 32'(got[0]), 32'h8701);
    check("t6_tail0", 32'(got[1]), 32'h4011);
    check("t6_head1", 32'(got[2]), 32'hB801);
    check("t6_tail1", 32'(got[3]), 32'h4022);
    for (int i = 1; i < 4; i++) begin
      check("t6_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd1);
    end
    check("t6_credits", 32'(credits_o),  32'd4);
    check("t6_err",     32'(cred_err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
